// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the MEM-stage load/store unit.
// Holds size/funct3 encodings, FSM state enum, decode bundle, extend helper.
package lsu_pkg;

    localparam logic [1:0] BYTE     = 2'b00;
    localparam logic [1:0] HALFWORD = 2'b01;
    localparam logic [1:0] WORD     = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] wdata;
        logic        fault;
    } lsu_dec_t;

    function automatic logic [31:0] lsu_extend(
        input logic [31:0] d,
        input logic [1:0]  size,
        input logic        sign_ext
    );
        logic [31:0] r;
        r = d;
        unique case (1'b1)
            (size == BYTE):
                r = {{24{sign_ext & d[7]}}, d[7:0]};
            (size == HALFWORD):
                r = {{16{sign_ext & d[15]}}, d[15:0]};
            default:
                r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_decode.sv
// lsu_decode: combinational funct3/store/address decode for the LSU.
// In: store, funct3, addr, wdata. Out: dec (size, sign_ext, masked wdata, fault).
module lsu_decode
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output lsu_dec_t    dec
);

    logic            bad_f3;
    logic            misalign;
    logic            out_range;
    logic            past_top;
    logic [2:0]      nbytes;
    logic [ADDR_W:0] last;

    always_comb begin
        bad_f3    = 1'b0;
        misalign  = 1'b0;
        nbytes    = 3'd1;
        dec       = '0;
        dec.wdata = wdata;
        unique case (1'b1)
            (funct3 == F3_B) || (funct3 == F3_BU): begin
                nbytes    = 3'd1;
                dec.wdata = {24'b0, wdata[7:0]};
            end
            (funct3 == F3_H) || (funct3 == F3_HU): begin
                nbytes    = 3'd2;
                misalign  = addr[0];
                dec.wdata = {16'b0, wdata[15:0]};
            end
            (funct3 == F3_W): begin
                nbytes    = 3'd4;
                misalign  = |addr[1:0];
                dec.wdata = wdata;
            end
            default: begin
                bad_f3 = 1'b1;
            end
        endcase

        out_range = |addr[31:ADDR_W];

        // One extra bit so the end address can reach exactly 2^ADDR_W.
        last = {1'b0, addr[ADDR_W-1:0]}
             + {{(ADDR_W-2){1'b0}}, nbytes};
        past_top = last > {1'b1, {ADDR_W{1'b0}}};

        dec.size     = funct3[1:0];
        dec.sign_ext = ~store & ~funct3[2];
        dec.fault    = bad_f3
                     | (store & funct3[2])
                     | out_range
                     | misalign
                     | past_top;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator on the data-memory port, one rsp per req.
// Req*/Rsp* pipeline handshake, Mem* memory port. Option: LSU_LOAD_EXT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqStore,
    input  logic [2:0]        ReqFunct3,
    input  logic [31:0]       ReqAddr,
    input  logic [31:0]       ReqData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [31:0]       RspData,
    output logic              RspFault,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic              MemSignExt,
    output logic [1:0]        MemSize,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemDataIn,
    input  logic [31:0]       MemDataOut
);

    lsu_state_t  state;
    logic [3:0]  cnt;
    lsu_dec_t    dec;
    logic [31:0] load_val;

    lsu_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .store  (ReqStore),
        .funct3 (ReqFunct3),
        .addr   (ReqAddr),
        .wdata  (ReqData),
        .dec    (dec)
    );

    // MemSize/MemSignExt are held through ACCESS and encode the
    // original funct3 of a load exactly, so they drive the extender.
`ifdef LSU_LOAD_EXT_EN
    assign load_val = lsu_extend(MemDataOut, MemSize, MemSignExt);
`else
    assign load_val = MemDataOut;
`endif

    assign ReqReady = (state == IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            RspValid     <= 1'b0;
            RspData      <= '0;
            RspFault     <= 1'b0;
            MemEnable    <= 1'b0;
            MemReadWrite <= 1'b0;
            MemSignExt   <= 1'b0;
            MemSize      <= BYTE;
            MemAddress   <= '0;
            MemDataIn    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        if (dec.fault) begin
                            state    <= RESP;
                            RspValid <= 1'b1;
                            RspFault <= 1'b1;
                            RspData  <= '0;
                        end else begin
                            state        <= ACCESS;
                            cnt          <= 4'(MEM_LAT - 1);
                            RspFault     <= 1'b0;
                            MemEnable    <= 1'b1;
                            MemReadWrite <= ReqStore;
                            MemSignExt   <= dec.sign_ext;
                            MemSize      <= dec.size;
                            MemAddress   <= ReqAddr[ADDR_W-1:0];
                            MemDataIn    <= dec.wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        MemEnable <= 1'b0;
                        RspValid  <= 1'b1;
                        RspData   <= MemReadWrite ? '0 : load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        state    <= IDLE;
                        RspValid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized + directed self-checking bench for the LSU.
// Reference model works on byte counts and plain integer address arithmetic.
module tb_load_store_unit;

    localparam int LAT = 3;
    localparam int AW  = 9;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          ReqValid = 1'b0;
    logic          ReqReady;
    logic          ReqStore = 1'b0;
    logic [2:0]    ReqFunct3 = 3'd0;
    logic [31:0]   ReqAddr = '0;
    logic [31:0]   ReqData = '0;
    logic          RspValid;
    logic          RspReady = 1'b0;
    logic [31:0]   RspData;
    logic          RspFault;
    logic          MemEnable;
    logic          MemReadWrite;
    logic          MemSignExt;
    logic [1:0]    MemSize;
    logic [AW-1:0] MemAddress;
    logic [31:0]   MemDataIn;
    logic [31:0]   MemDataOut = '0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(
        .MEM_LAT (LAT),
        .ADDR_W  (AW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqStore     (ReqStore),
        .ReqFunct3    (ReqFunct3),
        .ReqAddr      (ReqAddr),
        .ReqData      (ReqData),
        .RspValid     (RspValid),
        .RspReady     (RspReady),
        .RspData      (RspData),
        .RspFault     (RspFault),
        .MemEnable    (MemEnable),
        .MemReadWrite (MemReadWrite),
        .MemSignExt   (MemSignExt),
        .MemSize      (MemSize),
        .MemAddress   (MemAddress),
        .MemDataIn    (MemDataIn),
        .MemDataOut   (MemDataOut)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_fault(input bit st,
                                   input logic [2:0] f3,
                                   input logic [31:0] addr);
        longint a;
        int n;
        a = addr;
        n = nbytes(f3);
        if (n == 0) return 1;
        if (st && f3 >= 3'd4) return 1;
        if (a >= 512) return 1;
        if (a % n != 0) return 1;
        if (a + n > 512) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_rsp(input bit st,
                                          input logic [2:0] f3,
                                          input logic [31:0] rd);
        longint v;
        longint mask;
        int n;
        if (st) return 32'd0;
`ifdef LSU_LOAD_EXT_EN
        n = nbytes(f3);
        if (n == 4) return rd;
        mask = (longint'(1) << (8 * n)) - 1;
        v = longint'(rd) & mask;
        if (f3 < 3'd4 && v >= (mask + 1) / 2)
            v = v - (mask + 1);
        return 32'(v);
`else
        n = nbytes(f3);
        mask = 0;
        v = n;
        return rd;
`endif
    endfunction

    task automatic xact(input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rd, input int hold);
        bit flt;
        bit first;
        int n;
        int k;
        int en_cyc;
        logic [31:0] rsp_exp;
        logic [31:0] wmask;
        flt = m_fault(st, f3, addr);
        rsp_exp = flt ? 32'd0 : m_rsp(st, f3, rd);
        n = nbytes(f3);
        wmask = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        chk("req_ready_idle", 32'(ReqReady), 32'd1);
        ReqValid   = 1'b1;
        ReqStore   = st;
        ReqFunct3  = f3;
        ReqAddr    = addr;
        ReqData    = data;
        MemDataOut = rd;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        k = 0;
        en_cyc = 0;
        first = 1'b1;
        while (!RspValid && k < 40) begin
            if (MemEnable) begin
                en_cyc++;
                if (first) begin
                    first = 1'b0;
                    chk("mem_rw", 32'(MemReadWrite), 32'(st));
                    chk("mem_size", 32'(MemSize),
                        (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2);
                    chk("mem_sext", 32'(MemSignExt),
                        32'(!st && f3 < 3'd4));
                    chk("mem_addr", 32'(MemAddress), addr % 512);
                    chk("mem_wdata", MemDataIn, data & wmask);
                end
            end
            @(posedge Clk); #1;
            k++;
        end
        chk("rsp_seen", 32'(RspValid), 32'd1);
        chk("en_at_rsp", 32'(MemEnable), 32'd0);
        if (flt) begin
            chk("flt_lat", 32'(k <= 1), 32'd1);
            chk("flt_en_cycles", 32'(en_cyc), 32'd0);
        end else begin
            chk("rsp_lat", 32'(k), 32'(LAT));
            chk("en_cycles", 32'(en_cyc), 32'(LAT));
        end
        chk("rsp_fault", 32'(RspFault), 32'(flt));
        chk("rsp_data", RspData, rsp_exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            chk("hold_valid", 32'(RspValid), 32'd1);
            chk("hold_data", RspData, rsp_exp);
            chk("hold_ready", 32'(ReqReady), 32'd0);
        end
        RspReady = 1'b1;
        @(posedge Clk); #1;
        RspReady = 1'b0;
        chk("rsp_done_valid", 32'(RspValid), 32'd0);
        chk("rsp_done_ready", 32'(ReqReady), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          st;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_req_ready", 32'(ReqReady), 32'd1);
        chk("rst_rsp_valid", 32'(RspValid), 32'd0);
        chk("rst_rsp_data", RspData, 32'd0);
        chk("rst_rsp_fault", 32'(RspFault), 32'd0);
        chk("rst_mem_en", 32'(MemEnable), 32'd0);
        chk("rst_mem_size", 32'(MemSize), 32'd0);
        chk("rst_mem_addr", 32'(MemAddress), 32'd0);
        chk("rst_mem_wdata", MemDataIn, 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        xact(1'b1, 3'b000, 32'h1FF, 32'h12345678, 32'hA5A5A5A5, 0);
        xact(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 0);
        xact(1'b1, 3'b010, 32'h1FE, 32'h55, 32'h0, 0);
        xact(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0);
        xact(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1);
        xact(1'b1, 3'b100, 32'h8, 32'h1, 32'h0, 0);
        xact(1'b0, 3'b100, 32'h20, 32'h0, 32'hFFFFFF80, 4);
        xact(1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        xact(1'b0, 3'b101, 32'h1FE, 32'h0, 32'h1234F00D, 0);
        xact(1'b0, 3'b001, 32'h1FE, 32'h0, 32'h00008001, 2);
        xact(1'b1, 3'b001, 32'h1FE, 32'hCAFEBABE, 32'h0, 0);
        xact(1'b0, 3'b010, 32'h1FC, 32'h0, 32'h01020304, 0);

        // Reset during the second ACCESS cycle.
        ReqValid  = 1'b1;
        ReqStore  = 1'b0;
        ReqFunct3 = 3'b010;
        ReqAddr   = 32'h40;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk("pre_rst_en", 32'(MemEnable), 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("mid_rst_en", 32'(MemEnable), 32'd0);
        chk("mid_rst_valid", 32'(RspValid), 32'd0);
        chk("mid_rst_ready", 32'(ReqReady), 32'd1);
        chk("mid_rst_addr", 32'(MemAddress), 32'd0);
        xact(1'b0, 3'b000, 32'h44, 32'h0, 32'h0000007F, 0);

        // Reset and a request together: request dropped.
        Reset     = 1'b1;
        ReqValid  = 1'b1;
        ReqStore  = 1'b0;
        ReqFunct3 = 3'b010;
        ReqAddr   = 32'h48;
        @(posedge Clk); #1;
        Reset    = 1'b0;
        ReqValid = 1'b0;
        chk("rst_req_en", 32'(MemEnable), 32'd0);
        chk("rst_req_ready", 32'(ReqReady), 32'd1);
        @(posedge Clk); #1;
        chk("rst_req_en2", 32'(MemEnable), 32'd0);
        chk("rst_req_valid", 32'(RspValid), 32'd0);

        for (int t = 0; t < 60; t++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 3) == 0)
                addr = $urandom;
            else
                addr = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1)
                addr = addr & ~32'd3;
            xact(st, f3, addr, $urandom, $urandom,
                 int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
